// File: rtl/write_back_arbiter.sv
// Write-back arbiter: one holding slot per result source, round-robin
// grant into a single registered register-file write port.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   src_valid/src_ready  - per-source handshake
//   src_rd/src_data      - per-source destination index and result (packed)
//   src_is_link          - result is a PC; LINK_OFFSET is added at grant
//   flush                - drop every buffered, unwritten result
//   rf_we/rf_waddr/rf_wdata - registered register-file write port
//   busy                 - any holding slot occupied
module write_back_arbiter #(
   parameter int NUM_SRC     = 3,
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int LINK_OFFSET = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_ready,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
   input  logic [NUM_SRC*XLEN-1:0]       src_data,
   input  logic [NUM_SRC-1:0]            src_is_link,
   input  logic                          flush,
   output logic                          rf_we,
   output logic [REG_ADDR_W-1:0]         rf_waddr,
   output logic [XLEN-1:0]               rf_wdata,
   output logic                          busy
);

   localparam int PTR_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]                 slot_valid_q, slot_valid_d;
   logic [NUM_SRC-1:0][REG_ADDR_W-1:0] slot_rd_q, slot_rd_d;
   logic [NUM_SRC-1:0][XLEN-1:0]       slot_data_q, slot_data_d;
   logic [NUM_SRC-1:0]                 slot_link_q, slot_link_d;
   logic [PTR_W-1:0]                   ptr_q, ptr_d;
   logic                               rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0]              rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]                    rf_wdata_q, rf_wdata_d;

   logic [NUM_SRC-1:0]    gnt;
   logic                  gnt_any;
   logic [PTR_W-1:0]      gidx;
   logic [NUM_SRC-1:0]    hs;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic                  sel_link;

   // (p + k) mod NUM_SRC, with p < NUM_SRC and k <= NUM_SRC
   function automatic logic [PTR_W-1:0] rr_idx(
      input logic [PTR_W-1:0] p,
      input int               k
   );
      int s;
      s = int'(p) + k;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      return PTR_W'(s);
   endfunction

   // First valid slot at or after ptr, wrapping; nothing during flush
   always_comb begin
      gnt_any = 1'b0;
      gidx    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!gnt_any && slot_valid_q[rr_idx(ptr_q, k)]) begin
            gnt_any = 1'b1;
            gidx    = rr_idx(ptr_q, k);
         end
      end
      if (flush) gnt_any = 1'b0;
   end

   always_comb begin
      gnt      = '0;
      sel_rd   = '0;
      sel_data = '0;
      sel_link = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         gnt[i] = gnt_any && (gidx == PTR_W'(i));
         if (gnt[i]) begin
            sel_rd   = slot_rd_q[i];
            sel_data = slot_data_q[i];
            sel_link = slot_link_q[i];
         end
      end
   end

   // A slot being drained this cycle can accept its replacement
   assign src_ready = flush ? '0 : (~slot_valid_q | gnt);
   assign hs        = src_valid & src_ready;

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_rd_d    = slot_rd_q;
      slot_data_d  = slot_data_q;
      slot_link_d  = slot_link_q;
      ptr_d        = ptr_q;
      rf_we_d      = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      if (flush) begin
         slot_valid_d = '0;
         ptr_d        = '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) begin
               slot_valid_d[i] = 1'b1;
               slot_rd_d[i]    = src_rd[i*REG_ADDR_W +: REG_ADDR_W];
               slot_data_d[i]  = src_data[i*XLEN +: XLEN];
               slot_link_d[i]  = src_is_link[i];
            end else if (gnt[i]) begin
               slot_valid_d[i] = 1'b0;
            end
         end
         if (gnt_any) begin
            ptr_d      = rr_idx(gidx, 1);
            // x0 writes are consumed but never reach the register file
            rf_we_d    = (sel_rd != '0);
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_link ? sel_data + XLEN'(LINK_OFFSET)
                                  : sel_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_valid_q <= '0;
         ptr_q        <= '0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         ptr_q        <= ptr_d;
         rf_we_q      <= rf_we_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   // Payload needs no reset: it is only observed behind a valid bit
   always_ff @(posedge clk) begin
      slot_rd_q   <= slot_rd_d;
      slot_data_q <= slot_data_d;
      slot_link_q <= slot_link_d;
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy     = |slot_valid_q;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed self-checking bench for write_back_arbiter (3 sources).
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_write_back_arbiter;

   localparam int N  = 3;
   localparam int XL = 32;
   localparam int RW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*RW-1:0] src_rd;
   logic [N*XL-1:0] src_data;
   logic [N-1:0]    src_is_link;
   logic            flush;
   logic            rf_we;
   logic [RW-1:0]   rf_waddr;
   logic [XL-1:0]   rf_wdata;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   write_back_arbiter #(
      .NUM_SRC(N), .XLEN(XL), .REG_ADDR_W(RW), .LINK_OFFSET(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_rd(src_rd), .src_data(src_data),
      .src_is_link(src_is_link), .flush(flush),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_src(input int i, input logic [RW-1:0] rd,
                          input logic [XL-1:0] d, input logic lk);
      src_rd[i*RW +: RW]   = rd;
      src_data[i*XL +: XL] = d;
      src_is_link[i]       = lk;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      src_valid = '0;
      flush     = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      src_rd      = '0;
      src_data    = '0;
      src_is_link = '0;
      src_valid   = '0;
      flush       = 1'b0;
      rst_n       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(src_ready), 32'h7);

      // single write, 2-cycle latency
      set_src(0, 5'd5, 32'h1234, 1'b0);
      src_valid = 3'b001;
      tick();
      src_valid = '0;
      chk("lat1_we", 32'(rf_we), 32'd0);
      chk("lat1_busy", 32'(busy), 32'd1);
      tick();
      chk("lat2_we", 32'(rf_we), 32'd1);
      chk("lat2_waddr", 32'(rf_waddr), 32'd5);
      chk("lat2_wdata", rf_wdata, 32'h1234);
      chk("lat2_busy", 32'(busy), 32'd0);
      tick();
      chk("idle_we", 32'(rf_we), 32'd0);
      chk("idle_hold_waddr", 32'(rf_waddr), 32'd5);
      chk("idle_hold_wdata", rf_wdata, 32'h1234);

      // link results
      set_src(1, 5'd1, 32'h0000_1000, 1'b1);
      src_valid = 3'b010;
      tick();
      src_valid = '0;
      tick();
      chk("link_we", 32'(rf_we), 32'd1);
      chk("link_waddr", 32'(rf_waddr), 32'd1);
      chk("link_wdata", rf_wdata, 32'h0000_1004);
      set_src(1, 5'd1, 32'hFFFF_FFFE, 1'b1);
      src_valid = 3'b010;
      tick();
      src_valid = '0;
      tick();
      chk("linkwrap_wdata", rf_wdata, 32'h0000_0002);
      tick();

      // all sources streaming from reset
      do_reset();
      for (int i = 0; i < N; i++)
         set_src(i, RW'(i + 1), 32'hA0 + 32'(i), 1'b0);
      src_valid = 3'b111;
      #1;
      chk("rr_ready0", 32'(src_ready), 32'h7);
      tick();
      for (int k = 1; k <= 9; k++) begin
         chk("rr_ready", 32'(src_ready), 32'(1 << ((k - 1) % 3)));
         tick();
         chk("rr_we", 32'(rf_we), 32'd1);
         chk("rr_waddr", 32'(rf_waddr), 32'(((k - 1) % 3) + 1));
         chk("rr_wdata", rf_wdata, 32'hA0 + 32'((k - 1) % 3));
      end

      // x0 destination is consumed silently
      do_reset();
      set_src(0, 5'd7, 32'h77, 1'b0);
      set_src(2, 5'd0, 32'h99, 1'b0);
      src_valid = 3'b101;
      tick();
      src_valid = '0;
      tick();
      chk("x0_src0_we", 32'(rf_we), 32'd1);
      chk("x0_src0_waddr", 32'(rf_waddr), 32'd7);
      chk("x0_src0_wdata", rf_wdata, 32'h77);
      chk("x0_busy_mid", 32'(busy), 32'd1);
      tick();
      chk("x0_src2_we", 32'(rf_we), 32'd0);
      chk("x0_src2_busy", 32'(busy), 32'd0);
      tick();
      chk("x0_after_we", 32'(rf_we), 32'd0);

      // flush: move ptr to 1 first so its reset is observable
      set_src(0, 5'd4, 32'h44, 1'b0);
      set_src(2, 5'd6, 32'h66, 1'b0);
      src_valid = 3'b001;
      tick();
      src_valid = '0;
      tick();
      chk("pre_fl_waddr", 32'(rf_waddr), 32'd4);
      src_valid = 3'b101;
      tick();
      src_valid = 3'b001;
      flush     = 1'b1;
      #1;
      chk("fl_ready", 32'(src_ready), 32'd0);
      tick();
      flush     = 1'b0;
      src_valid = '0;
      chk("fl_we", 32'(rf_we), 32'd0);
      chk("fl_busy", 32'(busy), 32'd0);
      #1;
      chk("fl_ready_after", 32'(src_ready), 32'h7);
      tick();
      chk("fl_we2", 32'(rf_we), 32'd0);
      src_valid = 3'b101;
      tick();
      src_valid = '0;
      tick();
      chk("fl_ptr0_waddr", 32'(rf_waddr), 32'd4);
      tick();
      chk("fl_next_waddr", 32'(rf_waddr), 32'd6);
      tick();
      chk("fl_idle_we", 32'(rf_we), 32'd0);

      // reset mid-operation
      for (int i = 0; i < N; i++)
         set_src(i, RW'(i + 1), 32'hB0 + 32'(i), 1'b0);
      src_valid = 3'b111;
      tick();
      tick();
      tick();
      chk("mid_waddr", 32'(rf_waddr), 32'd2);
      chk("mid_we", 32'(rf_we), 32'd1);
      rst_n     = 1'b0;
      src_valid = '0;
      tick();
      rst_n = 1'b1;
      chk("mrst_we", 32'(rf_we), 32'd0);
      chk("mrst_waddr", 32'(rf_waddr), 32'd0);
      chk("mrst_wdata", rf_wdata, 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      #1;
      chk("mrst_ready", 32'(src_ready), 32'h7);
      src_valid = 3'b111;
      tick();
      src_valid = '0;
      tick();
      chk("mrst_first_waddr", 32'(rf_waddr), 32'd1);
      chk("mrst_first_wdata", rf_wdata, 32'hB0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
